// File: rtl/global_pool_stream.sv
// rtl/global_pool_stream.sv - streamed H x W x C global average/max pool with per-channel accumulators
// Results drain one channel per handshake; input is stalled while draining.
module global_pool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 8,
  parameter int W          = 8,
  parameter int C          = 4,
  parameter int RF         = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  valid_in,
  output logic                                  ready_in,
  input  logic signed [DATA_WIDTH-1:0]          pxl_in,
  input  logic                                  mode,
  output logic                                  valid_out,
  input  logic                                  ready_out,
  output logic signed [DATA_WIDTH-1:0]          pxl_out,
  output logic [((C > 1) ? $clog2(C) : 1)-1:0]  ch_out,
  output logic                                  busy
);

  localparam int NPIX      = H * W;
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(NPIX);
  localparam int RECIP     = ((1 << RF) + NPIX / 2) / NPIX;
  localparam int CW        = (C > 1) ? $clog2(C) : 1;
  localparam int PIW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PW        = ACC_WIDTH + RF + 2;

  localparam logic signed [PW-1:0] HALF  = PW'(1) << (RF - 1);
  localparam logic signed [PW-1:0] MAXV  = PW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] MINV  = ~MAXV;
  localparam logic signed [PW-1:0] RCP_S = PW'(RECIP);

  typedef enum logic [1:0] {S_ACC, S_LOAD, S_OUT} state_t;

  state_t                         state_q, state_d;
  logic signed [ACC_WIDTH-1:0]    acc [C];
  logic [CW-1:0]                  ci, oc, rd_idx;
  logic [PIW-1:0]                 pi;
  logic                           mode_q;
  logic                           accept, first_pix, last_pix, last_ch, last_oc;
  logic signed [ACC_WIDTH-1:0]    px_ext, acc_sel;
  logic signed [PW-1:0]           a_ext, prod, quo;
  logic signed [DATA_WIDTH-1:0]   avg_res, res;

  assign ready_in  = (state_q == S_ACC);
  assign accept    = valid_in && ready_in;
  assign first_pix = (pi == '0);
  assign last_pix  = (pi == PIW'(NPIX - 1));
  assign last_ch   = (ci == CW'(C - 1));
  assign last_oc   = (oc == CW'(C - 1));
  assign px_ext    = ACC_WIDTH'(pxl_in);
  assign ch_out    = oc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (accept && last_pix && last_ch) state_d = S_LOAD;
      S_LOAD:  state_d = S_OUT;
      S_OUT:   if (ready_out && last_oc) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // LOAD reads channel 0; OUT pre-reads the channel that follows the one on display.
  always_comb begin
    rd_idx = '0;
    if (state_q == S_OUT && !last_oc) rd_idx = oc + CW'(1);
    acc_sel = acc[rd_idx];
    a_ext   = PW'(acc_sel);
    prod    = a_ext * RCP_S;
    quo     = (prod + HALF) >>> RF;
    if (quo > MAXV)      avg_res = MAXV[DATA_WIDTH-1:0];
    else if (quo < MINV) avg_res = MINV[DATA_WIDTH-1:0];
    else                 avg_res = quo[DATA_WIDTH-1:0];
    res = mode_q ? acc_sel[DATA_WIDTH-1:0] : avg_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ACC;
      ci        <= '0;
      pi        <= '0;
      oc        <= '0;
      mode_q    <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      pxl_out   <= '0;
      for (int i = 0; i < C; i++) acc[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_ACC: begin
          if (accept) begin
            busy <= 1'b1;
            if (first_pix && ci == '0) mode_q <= mode;
            // The first pixel of a frame overwrites, so no clear pass is needed between frames.
            if (first_pix)                 acc[ci] <= px_ext;
            else if (mode_q) begin
              if (px_ext > acc[ci])        acc[ci] <= px_ext;
            end else                       acc[ci] <= acc[ci] + px_ext;
            if (last_ch) begin
              ci <= '0;
              pi <= last_pix ? '0 : pi + PIW'(1);
            end else begin
              ci <= ci + CW'(1);
            end
          end
        end
        S_LOAD: begin
          oc        <= '0;
          pxl_out   <= res;
          valid_out <= 1'b1;
        end
        S_OUT: begin
          if (ready_out) begin
            if (last_oc) begin
              valid_out <= 1'b0;
              busy      <= 1'b0;
              oc        <= '0;
            end else begin
              oc      <= oc + CW'(1);
              pxl_out <= res;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_global_pool_stream.sv
// tb/tb_global_pool_stream.sv - directed bench for global_pool_stream over three geometries
module tb_global_pool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // a: 8x8x1, b: 2x2x3, c: 3x3x1
  logic vi_a, vi_b, vi_c, md_a, md_b, md_c, ro_a, ro_b, ro_c;
  logic ri_a, ri_b, ri_c, vo_a, vo_b, vo_c, bz_a, bz_b, bz_c;
  logic signed [15:0] px_a, px_b, px_c, po_a, po_b, po_c;
  logic [0:0] co_a, co_c;
  logic [1:0] co_b;

  int checks = 0;
  int errors = 0;
  int vals[64];

  global_pool_stream #(.DATA_WIDTH(16), .H(8), .W(8), .C(1), .RF(16)) u_a (
    .clk(clk), .reset(reset), .valid_in(vi_a), .ready_in(ri_a), .pxl_in(px_a), .mode(md_a),
    .valid_out(vo_a), .ready_out(ro_a), .pxl_out(po_a), .ch_out(co_a), .busy(bz_a));
  global_pool_stream #(.DATA_WIDTH(16), .H(2), .W(2), .C(3), .RF(16)) u_b (
    .clk(clk), .reset(reset), .valid_in(vi_b), .ready_in(ri_b), .pxl_in(px_b), .mode(md_b),
    .valid_out(vo_b), .ready_out(ro_b), .pxl_out(po_b), .ch_out(co_b), .busy(bz_b));
  global_pool_stream #(.DATA_WIDTH(16), .H(3), .W(3), .C(1), .RF(16)) u_c (
    .clk(clk), .reset(reset), .valid_in(vi_c), .ready_in(ri_c), .pxl_in(px_c), .mode(md_c),
    .valid_out(vo_c), .ready_out(ro_c), .pxl_out(po_c), .ch_out(co_c), .busy(bz_c));

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input int d, input logic v, input int px, input logic m);
    case (d)
      0: begin vi_a = v; px_a = 16'(px); md_a = m; end
      1: begin vi_b = v; px_b = 16'(px); md_b = m; end
      default: begin vi_c = v; px_c = 16'(px); md_c = m; end
    endcase
  endtask

  task automatic set_ro(input int d, input logic r);
    case (d)
      0: ro_a = r;
      1: ro_b = r;
      default: ro_c = r;
    endcase
  endtask

  task automatic rd(input int d, output logic v, output logic r, output logic b,
                    output int p, output int c);
    case (d)
      0: begin v = vo_a; r = ri_a; b = bz_a; p = po_a; c = int'(co_a); end
      1: begin v = vo_b; r = ri_b; b = bz_b; p = po_b; c = int'(co_b); end
      default: begin v = vo_c; r = ri_c; b = bz_c; p = po_c; c = int'(co_c); end
    endcase
  endtask

  task automatic send_frame(input int d, input int n, input logic m0, input logic m1);
    for (int i = 0; i < n; i++) begin
      drv(d, 1'b1, vals[i], (i == 0) ? m0 : m1);
      @(posedge clk); #1;
    end
    drv(d, 1'b0, 0, 1'b0);
  endtask

  task automatic post_frame(input int d, input string tag);
    logic v, r, b; int p, c;
    rd(d, v, r, b, p, c);
    check({tag, "_valid_lo"}, v, 0);
    check({tag, "_ready_lo"}, r, 0);
    check({tag, "_busy"}, b, 1);
  endtask

  task automatic wait_valid(input int d, input string tag);
    logic v, r, b; int p, c;
    int t = 0;
    rd(d, v, r, b, p, c);
    while (!v && t < 20) begin
      @(posedge clk); #1;
      t++;
      rd(d, v, r, b, p, c);
    end
    if (!v) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic collect(input int d, input string tag, input int n,
                         input int e0, input int e1, input int e2);
    logic v, r, b; int p, c;
    int e[3];
    e = '{e0, e1, e2};
    for (int k = 0; k < n; k++) begin
      wait_valid(d, tag);
      rd(d, v, r, b, p, c);
      check($sformatf("%s_val%0d", tag, k), p, e[k]);
      check($sformatf("%s_ch%0d", tag, k), c, k);
      check($sformatf("%s_rdy%0d", tag, k), r, 0);
      @(posedge clk); #1;
    end
    rd(d, v, r, b, p, c);
    check({tag, "_end_valid"}, v, 0);
    check({tag, "_end_ready"}, r, 1);
    check({tag, "_end_busy"}, b, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic v, r, b; int p, c;
    int bp_exp[3];
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin drv(d, 1'b0, 0, 1'b0); set_ro(d, 1'b1); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    rd(0, v, r, b, p, c);
    check("rst_ready", r, 1); check("rst_valid", v, 0); check("rst_pxl", p, 0);
    check("rst_ch", c, 0);    check("rst_busy", b, 0);

    // Constant 5, with latency check on valid_out.
    for (int i = 0; i < 64; i++) vals[i] = 5;
    send_frame(0, 64, 1'b0, 1'b0);
    post_frame(0, "const5");
    @(posedge clk); #1;
    rd(0, v, r, b, p, c);
    check("const5_latency", v, 1);
    collect(0, "const5", 1, 5, 0, 0);

    // Ramps; mode toggled after the first beat must not matter.
    for (int i = 0; i < 64; i++) vals[i] = i;
    send_frame(0, 64, 1'b0, 1'b1);
    post_frame(0, "ramp_pos");
    collect(0, "ramp_pos", 1, 32, 0, 0);
    for (int i = 0; i < 64; i++) vals[i] = -(i + 1);
    send_frame(0, 64, 1'b0, 1'b0);
    collect(0, "ramp_neg", 1, -32, 0, 0);

    // Three-channel average.
    vals[0:11] = '{1, 10, -4, 3, 20, -4, 5, 30, -4, 7, 40, -4};
    send_frame(1, 12, 1'b0, 1'b0);
    post_frame(1, "c3avg");
    collect(1, "c3avg", 3, 4, 25, -4);

    // 3x3 average then back-to-back max frame.
    for (int i = 0; i < 9; i++) vals[i] = 5;
    send_frame(2, 9, 1'b0, 1'b1);
    collect(2, "avg3x3", 1, 5, 0, 0);
    vals[0:8] = '{-7, 3, -2, 1, 0, 9, -5, 4, 2};
    send_frame(2, 9, 1'b1, 1'b0);
    post_frame(2, "max3x3");
    collect(2, "max3x3", 1, 9, 0, 0);

    // Backpressure: hold each result for a cycle, offer beats during the drain.
    vals[0:11] = '{8, -6, 0, 8, -6, 4, 8, -6, 8, 8, -6, 12};
    bp_exp = '{8, -6, 6};
    send_frame(1, 12, 1'b0, 1'b0);
    post_frame(1, "bp");
    set_ro(1, 1'b0);
    drv(1, 1'b1, 100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_valid(1, "bp");
      @(posedge clk); #1;
      rd(1, v, r, b, p, c);
      check($sformatf("bp_hold_valid%0d", k), v, 1);
      check($sformatf("bp_hold_val%0d", k), p, bp_exp[k]);
      check($sformatf("bp_hold_ch%0d", k), c, k);
      check($sformatf("bp_hold_rdy%0d", k), r, 0);
      set_ro(1, 1'b1);
      @(posedge clk); #1;
      set_ro(1, 1'b0);
    end
    drv(1, 1'b0, 0, 1'b0);
    set_ro(1, 1'b1);
    rd(1, v, r, b, p, c);
    check("bp_end_valid", v, 0); check("bp_end_ready", r, 1); check("bp_end_busy", b, 0);

    // Reset mid-frame, then clean frames of 2s.
    for (int i = 0; i < 20; i++) vals[i] = 9;
    send_frame(0, 20, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(0, v, r, b, p, c);
    check("midrst_valid", v, 0); check("midrst_busy", b, 0); check("midrst_ready", r, 1);
    repeat (3) @(posedge clk);
    #1;
    rd(0, v, r, b, p, c);
    check("midrst_no_out", v, 0);
    for (int i = 0; i < 64; i++) vals[i] = 2;
    send_frame(0, 64, 1'b0, 1'b0);
    collect(0, "after_rst", 1, 2, 0, 0);
    send_frame(1, 12, 1'b0, 1'b0);
    collect(1, "after_bp", 3, 2, 2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
